dma_mem_arbiter: RTL and testbench

DMA_MEM_ARBITER -- requirements
Module: dma_mem_arbiter

---
 rtl/dma_mem_arbiter_pkg.sv | 34 +++
 rtl/dma_arb_slot.sv | 52 +++++
 rtl/dma_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_dma_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_mem_arbiter_pkg.sv
// Shared types and constants for the two-requester DMA memory arbiter.
package dma_mem_arbiter_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd1023;
    localparam int unsigned DATA_W          = 32'd32;
    localparam int unsigned CNT_W           = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Round-robin pick between eligible slots; on a tie the slot not granted last wins.
    function automatic req_id_t pick_grant(input logic elig_a, input logic elig_b,
                                           input req_id_t last_grant);
        req_id_t pick;
        if (elig_a && elig_b) begin
            pick = (last_grant == REQ_A) ? REQ_B : REQ_A;
        end else if (elig_a) begin
            pick = REQ_A;
        end else begin
            pick = REQ_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/dma_arb_slot.sv
// One requester slot: captures a strobe while idle, holds it until the arbiter
// completes it, and keeps the requester's last read result and error flag.
module dma_arb_slot
    import dma_mem_arbiter_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              done,
    input  logic              rsp_load,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_err,
    output logic              busy,
    output logic              op_wr,
    output logic [DATA_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    // Latch a new request only when free (rd+wr together counts as a write); free it on completion.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            op_wr     <= 1'b0;
            req_addr  <= {DATA_W{1'b0}};
            req_wdata <= {DATA_W{1'b0}};
        end else if (!busy && (rd || wr)) begin
            busy      <= 1'b1;
            op_wr     <= wr;
            req_addr  <= addr;
            req_wdata <= wdata;
        end else if (done) begin
            busy      <= 1'b0;
        end
    end

    // Read results (data or timeout marker) are only ever written by read completions.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rdata <= {DATA_W{1'b0}};
            err   <= 1'b0;
        end else if (rsp_load) begin
            rdata <= rsp_data;
            err   <= rsp_err;
        end
    end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Two-requester arbiter onto a single Avalon-MM master port, one transaction
// outstanding at a time, with a read-response watchdog. After a timeout the
// bus is "stale": a late response may still arrive, so reads stay blocked
// until it is seen (and dropped) or a second watchdog period expires.
module dma_mem_arbiter
    import dma_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        a_rd,
    input  logic        a_wr,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_busy,
    output logic        a_err,
    input  logic        b_rd,
    input  logic        b_wr,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_busy,
    output logic        b_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid
);

    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 32'd1);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    req_id_t           grant_r;
    req_id_t           grant_nxt_s;
    req_id_t           last_grant_r;
    req_id_t           last_grant_nxt_s;
    req_id_t           pick_s;
    logic              stale_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              a_op_wr_s;
    logic [31:0]       a_req_addr_s;
    logic [31:0]       a_req_wdata_s;
    logic              b_op_wr_s;
    logic [31:0]       b_req_addr_s;
    logic [31:0]       b_req_wdata_s;

    logic              elig_a_s;
    logic              elig_b_s;
    logic              grant_valid_s;
    logic              sel_wr_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              accept_s;
    logic              cnt_hit_s;
    logic              rd_valid_s;
    logic              rd_timeout_s;
    logic              rsp_load_s;
    logic [31:0]       rsp_data_s;
    logic              done_s;

    logic              mem_read_nxt_s;
    logic              mem_write_nxt_s;
    logic [31:0]       mem_address_nxt_s;
    logic [31:0]       mem_writedata_nxt_s;

    dma_arb_slot u_slot_a (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .rd        (a_rd),
        .wr        (a_wr),
        .addr      (a_addr),
        .wdata     (a_wdata),
        .done      (done_s && (grant_r == REQ_A)),
        .rsp_load  (rsp_load_s && (grant_r == REQ_A)),
        .rsp_data  (rsp_data_s),
        .rsp_err   (rd_timeout_s),
        .busy      (a_busy),
        .op_wr     (a_op_wr_s),
        .req_addr  (a_req_addr_s),
        .req_wdata (a_req_wdata_s),
        .rdata     (a_rdata),
        .err       (a_err)
    );

    dma_arb_slot u_slot_b (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .rd        (b_rd),
        .wr        (b_wr),
        .addr      (b_addr),
        .wdata     (b_wdata),
        .done      (done_s && (grant_r == REQ_B)),
        .rsp_load  (rsp_load_s && (grant_r == REQ_B)),
        .rsp_data  (rsp_data_s),
        .rsp_err   (rd_timeout_s),
        .busy      (b_busy),
        .op_wr     (b_op_wr_s),
        .req_addr  (b_req_addr_s),
        .req_wdata (b_req_wdata_s),
        .rdata     (b_rdata),
        .err       (b_err)
    );

    // While stale, only writes may be granted.
    assign elig_a_s      = a_busy && (!stale_r || a_op_wr_s);
    assign elig_b_s      = b_busy && (!stale_r || b_op_wr_s);
    assign grant_valid_s = elig_a_s || elig_b_s;
    assign pick_s        = pick_grant(elig_a_s, elig_b_s, last_grant_r);
    assign sel_wr_s      = (pick_s == REQ_A) ? a_op_wr_s     : b_op_wr_s;
    assign sel_addr_s    = (pick_s == REQ_A) ? a_req_addr_s  : b_req_addr_s;
    assign sel_wdata_s   = (pick_s == REQ_A) ? a_req_wdata_s : b_req_wdata_s;

    assign accept_s      = (state_r == ST_ISSUE) && !mem_waitrequest;
    assign cnt_hit_s     = (cnt_r == TIMEOUT_M1);
    assign rd_valid_s    = (state_r == ST_WAIT_RD) && mem_readdatavalid;
    assign rd_timeout_s  = (state_r == ST_WAIT_RD) && !mem_readdatavalid && cnt_hit_s;
    assign rsp_load_s    = rd_valid_s || rd_timeout_s;
    assign rsp_data_s    = rd_valid_s ? mem_readdata : 32'hFFFF_FFFF;
    assign done_s        = (state_r == ST_DONE);

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: grant, issue until accepted, wait for read data, one-cycle completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    state_nxt_s = mem_write ? ST_DONE : ST_WAIT_RD;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_RD: begin
                if (rsp_load_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_RD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered Avalon command and grant bookkeeping.
    always_comb begin
        mem_read_nxt_s      = 1'b0;
        mem_write_nxt_s     = 1'b0;
        mem_address_nxt_s   = mem_address;
        mem_writedata_nxt_s = mem_writedata;
        grant_nxt_s         = grant_r;
        last_grant_nxt_s    = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    mem_read_nxt_s      = !sel_wr_s;
                    mem_write_nxt_s     = sel_wr_s;
                    mem_address_nxt_s   = sel_addr_s;
                    mem_writedata_nxt_s = sel_wdata_s;
                    grant_nxt_s         = pick_s;
                end else begin
                    mem_read_nxt_s      = 1'b0;
                    mem_write_nxt_s     = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                end else begin
                    mem_read_nxt_s  = mem_read;
                    mem_write_nxt_s = mem_write;
                end
            end
            ST_DONE: begin
                last_grant_nxt_s = grant_r;
            end
            default: begin
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
            end
        endcase
    end

    // Register the Avalon command outputs and the grant history.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= 32'h0000_0000;
            mem_writedata <= 32'h0000_0000;
            grant_r       <= REQ_A;
            last_grant_r  <= REQ_B;
        end else begin
            mem_read      <= mem_read_nxt_s;
            mem_write     <= mem_write_nxt_s;
            mem_address   <= mem_address_nxt_s;
            mem_writedata <= mem_writedata_nxt_s;
            grant_r       <= grant_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
        end
    end

    // Watchdog: times WAIT_RD, then times the stale window that follows a timeout.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            stale_r <= 1'b0;
        end else if (accept_s && mem_read) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_WAIT_RD) begin
            if (mem_readdatavalid) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_hit_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                stale_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (stale_r) begin
            if (mem_readdatavalid || cnt_hit_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                stale_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed bench for dma_mem_arbiter with TIMEOUT=16; expected values are hand-computed.
module tb_dma_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        a_rd = 1'b0, a_wr = 1'b0;
    logic [31:0] a_addr = 32'h0, a_wdata = 32'h0;
    logic [31:0] a_rdata;
    logic        a_busy, a_err;
    logic        b_rd = 1'b0, b_wr = 1'b0;
    logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
    logic [31:0] b_rdata;
    logic        b_busy, b_err;
    logic [31:0] mem_address, mem_writedata;
    logic        mem_read, mem_write;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_readdatavalid = 1'b0;

    int errors = 0;
    int checks = 0;
    int cmd_cnt = 0;
    int cmd_base = 0;

    dma_mem_arbiter #(.TIMEOUT(16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_busy(a_busy), .a_err(a_err),
        .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_busy(b_busy), .b_err(b_err),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid)
    );

    always #5 clk_sys = ~clk_sys;

    // Count accepted Avalon commands.
    always @(posedge clk_sys) begin
        if (!reset && (mem_read || mem_write) && !mem_waitrequest) cmd_cnt <= cmd_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_a_busy", a_busy, 1'b0);
        chk1("rst_b_busy", b_busy, 1'b0);
        chk32("rst_a_rdata", a_rdata, 32'h0);
        chk32("rst_mem_address", mem_address, 32'h0);
        tick(); tick();
        reset = 1'b0;

        // Simultaneous reads, 3-cycle stall: A first (reset tie rule), then B
        tick();
        a_rd = 1'b1; a_addr = 32'h0000_2000;
        b_rd = 1'b1; b_addr = 32'h0000_3000;
        tick();                                              // T+1
        a_rd = 1'b0; b_rd = 1'b0; mem_waitrequest = 1'b1;
        chk1("tie_a_busy", a_busy, 1'b1);
        chk1("tie_b_busy", b_busy, 1'b1);
        chk1("tie_no_cmd_yet", mem_read, 1'b0);
        tick();                                              // T+2
        chk1("tie_rd_issue", mem_read, 1'b1);
        chk32("tie_a_first", mem_address, 32'h0000_2000);
        tick(); tick();                                      // T+4
        chk1("stall_hold_rd", mem_read, 1'b1);
        chk32("stall_hold_addr", mem_address, 32'h0000_2000);
        tick();                                              // T+5
        mem_waitrequest = 1'b0;
        tick();                                              // T+6
        chk1("wait_rd_cmd_low", mem_read, 1'b0);
        tick();                                              // T+7
        mem_readdatavalid = 1'b1; mem_readdata = 32'hA5A5_0001;
        tick();                                              // T+8
        mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
        chk32("a_rdata_done", a_rdata, 32'hA5A5_0001);
        chk1("a_busy_in_done", a_busy, 1'b1);
        tick();                                              // T+9
        chk1("a_busy_low", a_busy, 1'b0);
        chk1("a_err_ok", a_err, 1'b0);
        chk1("b_still_busy", b_busy, 1'b1);
        tick();                                              // T+10
        chk1("b_rd_issue", mem_read, 1'b1);
        chk32("b_second", mem_address, 32'h0000_3000);
        tick(); tick();                                      // T+12
        mem_readdatavalid = 1'b1; mem_readdata = 32'hB6B6_0002;
        tick();                                              // T+13
        mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
        tick();                                              // T+14
        chk1("b_busy_low", b_busy, 1'b0);
        chk32("b_rdata", b_rdata, 32'hB6B6_0002);
        chk1("b_err_ok", b_err, 1'b0);

        // Write from A, no stall: mem_write only at T+2, busy low at T+4
        a_wr = 1'b1; a_addr = 32'h0000_1000; a_wdata = 32'hDEAD_BEEF;
        tick();                                              // T+1
        a_wr = 1'b0;
        chk1("wr_busy_t1", a_busy, 1'b1);
        chk1("wr_no_cmd_t1", mem_write, 1'b0);
        tick();                                              // T+2
        chk1("wr_cmd_t2", mem_write, 1'b1);
        chk1("wr_not_read_t2", mem_read, 1'b0);
        chk32("wr_addr", mem_address, 32'h0000_1000);
        chk32("wr_data", mem_writedata, 32'hDEAD_BEEF);
        tick();                                              // T+3
        chk1("wr_cmd_low_t3", mem_write, 1'b0);
        chk1("wr_busy_t3", a_busy, 1'b1);
        tick();                                              // T+4
        chk1("wr_busy_low_t4", a_busy, 1'b0);
        chk1("wr_err_kept", a_err, 1'b0);
        chk32("wr_rdata_kept", a_rdata, 32'hA5A5_0001);

        // Tie after A was served: B wins; A's rd+wr strobe is a write
        a_rd = 1'b1; a_wr = 1'b1; a_addr = 32'h0000_1100; a_wdata = 32'h1111_1111;
        b_wr = 1'b1; b_addr = 32'h0000_2200; b_wdata = 32'h2222_2222;
        tick();                                              // T+1
        a_rd = 1'b0; a_wr = 1'b0; b_wr = 1'b0;
        tick();                                              // T+2
        chk32("tie2_b_wins", mem_address, 32'h0000_2200);
        chk32("tie2_b_data", mem_writedata, 32'h2222_2222);
        tick(); tick();                                      // T+4
        chk1("tie2_b_done", b_busy, 1'b0);
        tick();                                              // T+5
        chk1("rdwr_is_write", mem_write, 1'b1);
        chk1("rdwr_not_read", mem_read, 1'b0);
        chk32("tie2_a_addr", mem_address, 32'h0000_1100);
        tick(); tick();                                      // T+7
        chk1("tie2_a_done", a_busy, 1'b0);

        // Repeated strobe while busy is ignored
        cmd_base = cmd_cnt;
        a_rd = 1'b1; a_addr = 32'h0000_7000;
        tick();                                              // T+1
        a_rd = 1'b0; mem_waitrequest = 1'b1;
        tick();                                              // T+2
        a_wr = 1'b1; a_addr = 32'h0000_7777; a_wdata = 32'h7777_7777;
        tick();                                              // T+3
        a_wr = 1'b0;
        chk32("ignore_addr", mem_address, 32'h0000_7000);
        chk1("ignore_still_read", mem_read, 1'b1);
        chk1("ignore_no_write", mem_write, 1'b0);
        mem_waitrequest = 1'b0;
        tick();                                              // T+4
        mem_readdatavalid = 1'b1; mem_readdata = 32'h0BAD_0041;
        tick();                                              // T+5
        mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
        tick();                                              // T+6
        chk1("ignore_busy_low", a_busy, 1'b0);
        chk32("ignore_rdata", a_rdata, 32'h0BAD_0041);
        tick(); tick(); tick();
        chk1("ignore_no_extra_rd", mem_read, 1'b0);
        chk1("ignore_no_extra_wr", mem_write, 1'b0);
        chk32("ignore_one_cmd", 32'(cmd_cnt - cmd_base), 32'd1);

        // B read times out (TIMEOUT=16); stale blocks A read, allows A write
        b_rd = 1'b1; b_addr = 32'h0000_4000;
        tick();                                              // T+1
        b_rd = 1'b0;
        tick();                                              // T+2
        chk1("to_rd_issue", mem_read, 1'b1);
        chk32("to_addr", mem_address, 32'h0000_4000);
        repeat (16) tick();                                  // T+18
        chk1("to_busy_before", b_busy, 1'b1);
        chk1("to_err_before", b_err, 1'b0);
        tick();                                              // T+19
        chk32("to_rdata", b_rdata, 32'hFFFF_FFFF);
        chk1("to_err", b_err, 1'b1);
        tick();                                              // T+20
        chk1("to_busy_low", b_busy, 1'b0);
        a_wr = 1'b1; a_addr = 32'h0000_6000; a_wdata = 32'h6060_6060;
        tick();                                              // T+21
        a_wr = 1'b0;
        tick();                                              // T+22
        chk1("stale_wr_allowed", mem_write, 1'b1);
        chk32("stale_wr_addr", mem_address, 32'h0000_6000);
        tick(); tick();                                      // T+24
        chk1("stale_wr_done", a_busy, 1'b0);
        a_rd = 1'b1; a_addr = 32'h0000_5000;
        tick();                                              // T+25
        a_rd = 1'b0;
        tick();                                              // T+26
        chk1("stale_rd_blocked", mem_read, 1'b0);
        chk1("stale_rd_pending", a_busy, 1'b1);
        tick(); tick();                                      // T+28
        mem_readdatavalid = 1'b1; mem_readdata = 32'h1234_5678;
        tick();                                              // T+29
        mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
        tick();                                              // T+30
        chk1("stale_cleared_rd", mem_read, 1'b1);
        chk32("stale_cleared_addr", mem_address, 32'h0000_5000);
        tick();                                              // T+31
        mem_readdatavalid = 1'b1; mem_readdata = 32'hCAFE_0005;
        tick();                                              // T+32
        mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
        tick();                                              // T+33
        chk1("late_a_busy_low", a_busy, 1'b0);
        chk32("late_a_own_data", a_rdata, 32'hCAFE_0005);
        chk1("late_a_err", a_err, 1'b0);
        chk1("late_b_err_kept", b_err, 1'b1);

        // Reset while issuing: mem_read drops without a clock edge
        a_rd = 1'b1; a_addr = 32'h0000_8000;
        tick();
        a_rd = 1'b0; mem_waitrequest = 1'b1;
        tick();
        chk1("rst_issue_pre", mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("rst_async_rd", mem_read, 1'b0);
        chk1("rst_async_busy", a_busy, 1'b0);
        chk32("rst_async_addr", mem_address, 32'h0);
        tick();
        reset = 1'b0; mem_waitrequest = 1'b0;

        // Reset during WAIT_RD: no completion, stale stays clear
        b_rd = 1'b1; b_addr = 32'h0000_9000;
        tick();
        b_rd = 1'b0;
        tick();
        chk1("rst_wait_issue", mem_read, 1'b1);
        tick(); tick();                                      // in WAIT_RD
        #2 reset = 1'b1;
        #1;
        chk1("rst_wait_busy", b_busy, 1'b0);
        chk1("rst_wait_rd", mem_read, 1'b0);
        chk32("rst_wait_rdata", b_rdata, 32'h0);
        chk1("rst_wait_err", b_err, 1'b0);
        tick();
        reset = 1'b0;
        a_rd = 1'b1; a_addr = 32'h0000_A000;
        tick();
        a_rd = 1'b0;
        tick();
        chk1("post_rst_rd_not_stale", mem_read, 1'b1);
        chk32("post_rst_addr", mem_address, 32'h0000_A000);
        tick();
        mem_readdatavalid = 1'b1; mem_readdata = 32'h00AA_0042;
        tick();
        mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
        tick();
        chk32("post_rst_rdata", a_rdata, 32'h00AA_0042);
        mem_readdatavalid = 1'b1; mem_readdata = 32'h1234_5678;
        tick();
        mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
        tick(); tick();
        chk32("late_after_rst_b", b_rdata, 32'h0);
        chk1("late_after_rst_b_busy", b_busy, 1'b0);
        chk32("late_after_rst_a", a_rdata, 32'h00AA_0042);
        chk1("late_after_rst_idle", mem_read, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
